// File: rtl/lif_neuron_step.sv
// Leaky integrate-and-fire neuron: one sign-magnitude Q16.16 Euler step per accepted request,
// sequenced over LEAK/DRIVE/INTEG/FIRE with a valid/ready result handshake.
module lif_neuron_step #(
    parameter int unsigned    N       = 32,
    parameter int unsigned    Q       = 16,
    parameter int unsigned    REFRACT = 2,
    parameter logic [N-1:0]   V_INIT  = 32'h80410000,
    parameter int unsigned    CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     i_syn,
    input  logic [N-1:0]     v_rest,
    input  logic [N-1:0]     v_thresh,
    input  logic [N-1:0]     v_reset,
    input  logic [N-1:0]     leak,
    input  logic [N-1:0]     gain,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             spike,
    output logic [N-1:0]     v_out,
    output logic [CNT_W-1:0] spike_count
);

    localparam int unsigned  RW      = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
    localparam logic [N-2:0] MAG_MAX = '1;

    typedef enum logic [2:0] {StIdle, StLeak, StDrive, StInteg, StFire, StOut} state_e;

    function automatic logic [N-1:0] sm_add(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] sum;
        logic [N-1:0] res;
        sum = {1'b0, a[N-2:0]} + {1'b0, b[N-2:0]};
        if (a[N-1] == b[N-1]) begin
            res = {a[N-1], sum[N-1] ? MAG_MAX : sum[N-2:0]};
        end else if (a[N-2:0] >= b[N-2:0]) begin
            res = {a[N-1], a[N-2:0] - b[N-2:0]};
        end else begin
            res = {b[N-1], b[N-2:0] - a[N-2:0]};
        end
        if (res[N-2:0] == '0) res = '0;
        return res;
    endfunction

    function automatic logic [N-1:0] sm_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [2*N-3:0] prod;
        logic [N-2:0]   mag;
        logic [N-1:0]   res;
        prod = {{(N-1){1'b0}}, a[N-2:0]} * {{(N-1){1'b0}}, b[N-2:0]};
        mag  = (|prod[2*N-3:Q+N-1]) ? MAG_MAX : prod[Q+N-2:Q];
        res  = {a[N-1] ^ b[N-1], mag};
        if (mag == '0) res = '0;
        return res;
    endfunction

    // Negative zero is folded to positive before comparing signs.
    function automatic logic sm_ge(input logic [N-1:0] a, input logic [N-1:0] b);
        logic sa;
        logic sb;
        sa = a[N-1] & (|a[N-2:0]);
        sb = b[N-1] & (|b[N-2:0]);
        if (sa != sb) return !sa;
        if (!sa) return a[N-2:0] >= b[N-2:0];
        return a[N-2:0] <= b[N-2:0];
    endfunction

    state_e           state_q, state_d;
    logic [N-1:0]     v_q, v_next_q, leak_term_q, drive_q, v_out_q;
    logic [N-1:0]     i_syn_q, v_rest_q, v_thresh_q, v_reset_q, leak_q, gain_q;
    logic [RW-1:0]    refr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             spike_q, out_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (in_valid) state_d = StLeak;
                StLeak:  state_d = StDrive;
                StDrive: state_d = StInteg;
                StInteg: state_d = StFire;
                StFire:  state_d = StOut;
                StOut:   if (out_ready) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q         <= V_INIT;
            v_next_q    <= '0;
            leak_term_q <= '0;
            drive_q     <= '0;
            v_out_q     <= V_INIT;
            i_syn_q     <= '0;
            v_rest_q    <= '0;
            v_thresh_q  <= '0;
            v_reset_q   <= '0;
            leak_q      <= '0;
            gain_q      <= '0;
            refr_q      <= '0;
            cnt_q       <= '0;
            spike_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (clear) begin
            v_q         <= v_reset;
            v_out_q     <= v_reset;
            refr_q      <= '0;
            spike_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: if (in_valid) begin
                    i_syn_q    <= i_syn;
                    v_rest_q   <= v_rest;
                    v_thresh_q <= v_thresh;
                    v_reset_q  <= v_reset;
                    leak_q     <= leak;
                    gain_q     <= gain;
                end
                StLeak:  leak_term_q <= sm_mul(leak_q, sm_add(v_rest_q, {~v_q[N-1], v_q[N-2:0]}));
                StDrive: drive_q <= sm_mul(gain_q, i_syn_q);
                StInteg: v_next_q <= sm_add(sm_add(v_q, leak_term_q), drive_q);
                StFire: begin
                    out_valid_q <= 1'b1;
                    if (refr_q != '0) begin
                        v_q     <= v_reset_q;
                        v_out_q <= v_reset_q;
                        spike_q <= 1'b0;
                        refr_q  <= refr_q - 1'b1;
                    end else if (sm_ge(v_next_q, v_thresh_q)) begin
                        v_q     <= v_reset_q;
                        v_out_q <= v_reset_q;
                        spike_q <= 1'b1;
                        refr_q  <= RW'(REFRACT);
                        if (~&cnt_q) cnt_q <= cnt_q + 1'b1;
                    end else begin
                        v_q     <= v_next_q;
                        v_out_q <= v_next_q;
                        spike_q <= 1'b0;
                    end
                end
                StOut: if (out_ready) out_valid_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign in_ready    = (state_q == StIdle);
    assign out_valid   = out_valid_q;
    assign spike       = spike_q;
    assign v_out       = v_out_q;
    assign spike_count = cnt_q;

endmodule

// File: tb/tb_lif_neuron_step.sv
// Scoreboard bench for lif_neuron_step: an integer-arithmetic reference model predicts each
// step's v_out/spike/spike_count at acceptance; results are popped and compared on out_valid.
module tb_lif_neuron_step;

    localparam logic [31:0] V_INIT = 32'h80410000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] i_syn = '0, v_rest = '0, v_thresh = '0, v_reset = '0, leak = '0, gain = '0;
    logic        clear = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        spike;
    logic [31:0] v_out;
    logic [7:0]  spike_count;

    lif_neuron_step #(.REFRACT(2), .V_INIT(V_INIT), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .i_syn(i_syn), .v_rest(v_rest), .v_thresh(v_thresh), .v_reset(v_reset),
        .leak(leak), .gain(gain), .clear(clear), .out_valid(out_valid),
        .out_ready(out_ready), .spike(spike), .v_out(v_out), .spike_count(spike_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] v;
        logic        spk;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] m_v = V_INIT;
    int          m_refr = 0;
    logic [7:0]  m_cnt = '0;

    function automatic longint to_int(input logic [31:0] a);
        longint m;
        m = longint'(a[30:0]);
        return a[31] ? -m : m;
    endfunction

    function automatic logic [31:0] from_int(input longint x);
        longint      m;
        logic [31:0] r;
        m = (x < 0) ? -x : x;
        if (m > 64'sh7FFFFFFF) m = 64'sh7FFFFFFF;
        if (m == 0) return 32'h0;
        r[31]   = (x < 0);
        r[30:0] = m[30:0];
        return r;
    endfunction

    function automatic logic [31:0] m_mul(input logic [31:0] a, input logic [31:0] b);
        longint      p;
        logic [31:0] r;
        p = (longint'(a[30:0]) * longint'(b[30:0])) >>> 16;
        if (p > 64'sh7FFFFFFF) p = 64'sh7FFFFFFF;
        if (p == 0) return 32'h0;
        r[31]   = a[31] ^ b[31];
        r[30:0] = p[30:0];
        return r;
    endfunction

    task automatic model_accept();
        logic [31:0] lt, dr, vn;
        exp_t        e;
        lt = m_mul(leak, from_int(to_int(v_rest) - to_int(m_v)));
        dr = m_mul(gain, i_syn);
        vn = from_int(to_int(from_int(to_int(m_v) + to_int(lt))) + to_int(dr));
        if (m_refr != 0) begin
            m_v = v_reset; m_refr--; e.spk = 1'b0;
        end else if (to_int(vn) >= to_int(v_thresh)) begin
            m_v = v_reset; m_refr = 2; e.spk = 1'b1;
            if (m_cnt != 8'hFF) m_cnt++;
        end else begin
            m_v = vn; e.spk = 1'b0;
        end
        e.v = m_v;
        e.cnt = m_cnt;
        sb_q.push_back(e);
    endtask

    task automatic model_clear();
        m_v = v_reset;
        m_refr = 0;
        sb_q.delete();
    endtask

    task automatic set_cfg(input logic [31:0] is, vr, vt, vs, lk, gn);
        i_syn = is; v_rest = vr; v_thresh = vt; v_reset = vs; leak = lk; gain = gn;
    endtask

    task automatic drive_step();
        int n;
        n = 0;
        while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
        total++;
        if (!in_ready) begin
            bad++; $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1;
        @(posedge clk);
        model_accept();
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_result(output exp_t got);
        int n;
        n = 0;
        got = '0;
        while (!out_valid && n < 12) begin @(posedge clk); #1; n++; end
        total++;
        if (n != 4 || !out_valid) begin
            bad++; $display("FAIL latency: edges=%0d out_valid=%b required 4 and 1", n, out_valid);
        end
        total++;
        if (sb_q.size() == 0) begin
            bad++; $display("FAIL scoreboard: no expected entry queued");
        end else begin
            got = sb_q.pop_front();
            total++;
            if (v_out !== got.v) begin
                bad++; $display("FAIL v_out: got %h required %h", v_out, got.v);
            end
            total++;
            if (spike !== got.spk) begin
                bad++; $display("FAIL spike: got %b required %b", spike, got.spk);
            end
            total++;
            if (spike_count !== got.cnt) begin
                bad++; $display("FAIL spike_count: got %h required %h", spike_count, got.cnt);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({in_ready, out_valid, spike} !== 3'b100) begin
            bad++; $display("FAIL reset_flags: rdy/vld/spk=%b required 100",
                            {in_ready, out_valid, spike});
        end
        total++;
        if (v_out !== V_INIT || spike_count !== 8'h00) begin
            bad++; $display("FAIL reset_values: v_out=%h cnt=%h required %h 00",
                            v_out, spike_count, V_INIT);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_equilibrium();
        exp_t g;
        set_cfg(32'h0, 32'h80410000, 32'h80320000, 32'h80460000, 32'h0000199A, 32'h00010000);
        drive_step();
        wait_result(g);
        total++;
        if (v_out !== 32'h80410000 || spike !== 1'b0) begin
            bad++; $display("FAIL equilibrium: v_out=%h spike=%b required 80410000 0", v_out, spike);
        end
    endtask

    task automatic test_fire_refractory();
        exp_t g;
        logic exp_spk[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        set_cfg(32'h00140000, 32'h80410000, 32'h80320000, 32'h80460000, 32'h0000199A,
                32'h00010000);
        for (int s = 0; s < 4; s++) begin
            drive_step();
            wait_result(g);
            total++;
            if (spike !== exp_spk[s] || v_out !== 32'h80460000) begin
                bad++; $display("FAIL fire_step%0d: spike=%b v_out=%h required %b 80460000",
                                s + 1, spike, v_out, exp_spk[s]);
            end
        end
        total++;
        if (spike_count !== 8'd2) begin
            bad++; $display("FAIL fire_count: got %0d required 2", spike_count);
        end
    endtask

    task automatic test_back_to_back();
        int   acc[$];
        logic rdy;
        exp_t e;
        set_cfg(32'h0, 32'h80410000, 32'h80320000, 32'h80460000, 32'h0000199A, 32'h00010000);
        while (!in_ready) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            rdy = in_ready;
            @(posedge clk);
            if (rdy) begin model_accept(); acc.push_back(c); end
            #1;
            if (out_valid) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++; $display("FAIL b2b_scoreboard: unexpected out_valid");
                end else begin
                    e = sb_q.pop_front();
                    total++;
                    if ({v_out, spike, spike_count} !== {e.v, e.spk, e.cnt}) begin
                        bad++; $display("FAIL b2b_result: got %h/%b/%h required %h/%b/%h",
                                        v_out, spike, spike_count, e.v, e.spk, e.cnt);
                    end
                end
            end
        end
        in_valid = 1'b0;
        total++;
        if (acc.size() != 5) begin
            bad++; $display("FAIL b2b_accepts: got %0d required 5", acc.size());
        end
        for (int k = 1; k < acc.size(); k++) begin
            total++;
            if (acc[k] - acc[k-1] != 6) begin
                bad++; $display("FAIL b2b_spacing: got %0d required 6", acc[k] - acc[k-1]);
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t g;
        out_ready = 1'b0;
        set_cfg(32'h00030000, 32'h80410000, 32'h80320000, 32'h80460000, 32'h0000199A,
                32'h00010000);
        drive_step();
        wait_result(g);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            total++;
            if (!out_valid || in_ready || v_out !== g.v || spike !== g.spk) begin
                bad++; $display("FAIL backpressure_hold: vld=%b rdy=%b v_out=%h spk=%b required 1 0 %h %b",
                                out_valid, in_ready, v_out, spike, g.v, g.spk);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (out_valid || !in_ready) begin
            bad++; $display("FAIL backpressure_release: vld=%b rdy=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_clear();
        exp_t g;
        set_cfg(32'h00050000, 32'h80410000, 32'h80320000, 32'h80460000, 32'h0000199A,
                32'h00010000);
        drive_step();
        clear = 1'b1;
        @(posedge clk);
        model_clear();
        #1 clear = 1'b0;
        total++;
        if (out_valid || !in_ready || v_out !== 32'h80460000) begin
            bad++; $display("FAIL clear_state: vld=%b rdy=%b v_out=%h required 0 1 80460000",
                            out_valid, in_ready, v_out);
        end
        set_cfg(32'h0, 32'h80410000, 32'h80320000, 32'h80460000, 32'h0, 32'h00010000);
        drive_step();
        wait_result(g);
        total++;
        if (v_out !== 32'h80460000) begin
            bad++; $display("FAIL clear_followup: v_out=%h required 80460000", v_out);
        end
        while (!in_ready) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        clear = 1'b1;
        @(posedge clk);
        model_clear();
        #1;
        in_valid = 1'b0;
        clear = 1'b0;
        total++;
        if (!in_ready || out_valid) begin
            bad++; $display("FAIL clear_beats_valid: rdy=%b vld=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_saturation();
        exp_t g;
        set_cfg(32'h7D000000, 32'h7D000000, 32'h7FFFFFFF, 32'h7D000000, 32'h0, 32'h00010000);
        clear = 1'b1;
        @(posedge clk);
        model_clear();
        #1 clear = 1'b0;
        drive_step();
        wait_result(g);
        total++;
        if (spike !== 1'b1 || v_out !== 32'h7D000000) begin
            bad++; $display("FAIL saturate_add: spike=%b v_out=%h required 1 7d000000", spike, v_out);
        end
        for (int s = 0; s < 780; s++) begin
            drive_step();
            wait_result(g);
        end
        total++;
        if (spike_count !== 8'hFF) begin
            bad++; $display("FAIL count_saturate: got %h required ff", spike_count);
        end
    endtask

    task automatic test_reset_mid();
        exp_t g;
        set_cfg(32'h0, 32'h80410000, 32'h80320000, 32'h80460000, 32'h0000199A, 32'h00010000);
        drive_step();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        m_v = V_INIT; m_refr = 0; m_cnt = '0; sb_q.delete();
        total++;
        if (out_valid || !in_ready || v_out !== V_INIT || spike_count !== 8'h00) begin
            bad++; $display("FAIL reset_mid: vld=%b rdy=%b v_out=%h cnt=%h required 0 1 %h 00",
                            out_valid, in_ready, v_out, spike_count, V_INIT);
        end
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        drive_step();
        wait_result(g);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        @(negedge clk);
        test_equilibrium();
        test_fire_refractory();
        test_back_to_back();
        test_backpressure();
        test_clear();
        test_saturation();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
